// File: rtl/tx_packet_fifo_if.sv
// Byte stream from the transmit FIFO to the modulator.
// Plain valid/ready handshake; a byte moves on valid && ready.
interface tx_packet_fifo_if;
  logic [7:0] tx_byte;
  logic       tx_valid;
  logic       tx_ready;

  modport master (
    output tx_byte,
    output tx_valid,
    input  tx_ready
  );

  modport slave (
    input  tx_byte,
    input  tx_valid,
    output tx_ready
  );
endinterface

// File: rtl/tx_packet_fifo.sv
// Transmit byte FIFO: buffers driver writes and streams
// size-limited packets to the modulator on start_tx.
module tx_packet_fifo #(
  parameter int DEPTH = 256,
  parameter int CNT_W = 9
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       data_tx,
  input  logic             wren_fifo_tx,
  input  logic [7:0]       size_fifo_tx,
  input  logic             start_tx,
  output logic             ready_tx,
  tx_packet_fifo_if.master tx,
  output logic             tx_done,
  output logic [CNT_W-1:0] fifo_count,
  output logic             overflow,
  output logic             underrun,
  input  logic             clr_flags
);

  localparam int AW = CNT_W - 1;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SEND,
    DONE
  } state_t;

  state_t state, state_nx;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [7:0]    rd_data;
  logic [7:0]    remaining, remaining_nx;
  logic [8:0]    cnt9;
  logic          full, wr_ok, rd_fire;
  logic          ov_set, ur_set;

  assign cnt9    = 9'(fifo_count);
  assign full    = fifo_count == CNT_W'(DEPTH);
  assign wr_ok   = wren_fifo_tx && !full;
  assign ov_set  = wren_fifo_tx && full;
  assign rd_fire = (state == SEND) && tx.tx_ready;

  assign ready_tx    = state == IDLE;
  assign tx.tx_valid = state == SEND;
  assign tx.tx_byte  = (state == SEND) ? rd_data : 8'h00;
  assign tx_done     = state == DONE;

  always_comb begin
    state_nx     = state;
    remaining_nx = remaining;
    ur_set       = 1'b0;
    unique case (state)
      IDLE: begin
        if (start_tx && size_fifo_tx != 8'd0) begin
          ur_set = {1'b0, size_fifo_tx} > cnt9;
          if (fifo_count != '0) begin
            // Short request: send only what is stored.
            remaining_nx = ur_set ? cnt9[7:0] : size_fifo_tx;
            state_nx     = LOAD;
          end
        end
      end
      LOAD: state_nx = SEND;
      SEND: begin
        if (tx.tx_ready) begin
          remaining_nx = remaining - 8'd1;
          state_nx     = (remaining == 8'd1) ? DONE : LOAD;
        end
      end
      DONE: state_nx = IDLE;
    endcase
  end

  // RAM holds no reset; tx_byte is gated outside SEND.
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr] <= data_tx;
    if (state == LOAD) rd_data <= mem[rd_ptr];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      remaining  <= 8'd0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      overflow   <= 1'b0;
      underrun   <= 1'b0;
    end else begin
      state     <= state_nx;
      remaining <= remaining_nx;
      if (wr_ok)   wr_ptr <= wr_ptr + AW'(1);
      if (rd_fire) rd_ptr <= rd_ptr + AW'(1);
      fifo_count <= fifo_count + CNT_W'(wr_ok)
                  - CNT_W'(rd_fire);
      overflow <= ov_set || (overflow && !clr_flags);
      underrun <= ur_set || (underrun && !clr_flags);
    end
  end

endmodule

// File: tb/tb_tx_packet_fifo.sv
// Directed bench for tx_packet_fifo: a cycle table for the
// basic packet plus sequences for overflow, stall, wrap, reset.
module tb_tx_packet_fifo;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] data_tx;
  logic       wren_fifo_tx;
  logic [7:0] size_fifo_tx;
  logic       start_tx;
  logic       ready_tx;
  logic       tx_done;
  logic [8:0] fifo_count;
  logic       overflow;
  logic       underrun;
  logic       clr_flags;

  tx_packet_fifo_if tx_if ();

  tx_packet_fifo #(
    .DEPTH(256),
    .CNT_W(9)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .data_tx     (data_tx),
    .wren_fifo_tx(wren_fifo_tx),
    .size_fifo_tx(size_fifo_tx),
    .start_tx    (start_tx),
    .ready_tx    (ready_tx),
    .tx          (tx_if),
    .tx_done     (tx_done),
    .fifo_count  (fifo_count),
    .overflow    (overflow),
    .underrun    (underrun),
    .clr_flags   (clr_flags)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       wr;
    logic [7:0] d;
    logic       st;
    logic [7:0] sz;
    logic       clr;
    logic       e_rdy;
    logic       e_vld;
    logic [7:0] e_byte;
    logic       e_done;
    logic [8:0] e_cnt;
    logic       e_ur;
  } vec_t;

  vec_t       vt[$];
  logic [7:0] got[$];
  logic       done_seen;
  int         nvec = 0;
  int         nbad = 0;

  function automatic vec_t mk(
    logic wr, logic [7:0] d, logic st, logic [7:0] sz,
    logic clr, logic rdy, logic vld, logic [7:0] b,
    logic done, logic [8:0] cnt, logic ur);
    vec_t v;
    v.wr = wr; v.d = d; v.st = st; v.sz = sz; v.clr = clr;
    v.e_rdy = rdy; v.e_vld = vld; v.e_byte = b;
    v.e_done = done; v.e_cnt = cnt; v.e_ur = ur;
    return v;
  endfunction

  task automatic chk(string nm, logic [31:0] act,
                     logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h",
               nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cyc();
    cyc();
    reset = 1'b0;
  endtask

  task automatic wr_byte(logic [7:0] d);
    wren_fifo_tx = 1'b1;
    data_tx      = d;
    cyc();
    wren_fifo_tx = 1'b0;
  endtask

  task automatic start_pkt(logic [7:0] sz);
    start_tx     = 1'b1;
    size_fifo_tx = sz;
    cyc();
    start_tx = 1'b0;
  endtask

  // Accepts one byte at a time; optionally stalls on one index.
  task automatic recv(int stall_idx, int stall_n,
                      logic [7:0] stall_exp, int limit);
    got.delete();
    done_seen = 1'b0;
    for (int t = 0; t < limit && !done_seen; t++) begin
      if (tx_done) begin
        done_seen = 1'b1;
      end else if (tx_if.tx_valid) begin
        if (got.size() == stall_idx) begin
          for (int s = 0; s < stall_n; s++) begin
            cyc();
            chk($sformatf("stall%0d.vld", s),
                32'(tx_if.tx_valid), 1);
            chk($sformatf("stall%0d.byte", s),
                32'(tx_if.tx_byte), 32'(stall_exp));
          end
        end
        got.push_back(tx_if.tx_byte);
        tx_if.tx_ready = 1'b1;
        cyc();
        tx_if.tx_ready = 1'b0;
      end else begin
        cyc();
      end
    end
    chk("recv.done", 32'(done_seen), 1);
    if (done_seen) cyc();
  endtask

  task automatic chk_got(string nm, int n, int base);
    chk({nm, ".len"}, got.size(), n);
    for (int i = 0; i < n && i < got.size(); i++)
      chk($sformatf("%s.b%0d", nm, i), 32'(got[i]),
          32'((base + i) & 8'hff));
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset          = 1'b1;
    data_tx        = 8'h00;
    wren_fifo_tx   = 1'b0;
    size_fifo_tx   = 8'h00;
    start_tx       = 1'b0;
    clr_flags      = 1'b0;
    tx_if.tx_ready = 1'b0;

    // Basic 3-byte packet, empty/zero starts, flag clear.
    vt.push_back(mk(0,8'h00,0,8'd0,0, 1,0,8'h00,0,9'd0,0));
    vt.push_back(mk(1,8'h11,0,8'd0,0, 1,0,8'h00,0,9'd1,0));
    vt.push_back(mk(1,8'h22,0,8'd0,0, 1,0,8'h00,0,9'd2,0));
    vt.push_back(mk(1,8'h33,0,8'd0,0, 1,0,8'h00,0,9'd3,0));
    vt.push_back(mk(0,8'h00,1,8'd3,0, 0,0,8'h00,0,9'd3,0));
    vt.push_back(mk(0,8'h00,0,8'd0,0, 0,1,8'h11,0,9'd3,0));
    vt.push_back(mk(0,8'h00,0,8'd0,0, 0,0,8'h00,0,9'd2,0));
    vt.push_back(mk(0,8'h00,0,8'd0,0, 0,1,8'h22,0,9'd2,0));
    vt.push_back(mk(0,8'h00,0,8'd0,0, 0,0,8'h00,0,9'd1,0));
    vt.push_back(mk(0,8'h00,0,8'd0,0, 0,1,8'h33,0,9'd1,0));
    vt.push_back(mk(0,8'h00,0,8'd0,0, 0,0,8'h00,1,9'd0,0));
    vt.push_back(mk(0,8'h00,0,8'd0,0, 1,0,8'h00,0,9'd0,0));
    vt.push_back(mk(0,8'h00,1,8'd0,0, 1,0,8'h00,0,9'd0,0));
    vt.push_back(mk(0,8'h00,1,8'd4,0, 1,0,8'h00,0,9'd0,1));
    vt.push_back(mk(0,8'h00,0,8'd0,1, 1,0,8'h00,0,9'd0,0));
    vt.push_back(mk(1,8'h44,1,8'd1,0, 1,0,8'h00,0,9'd1,1));
    vt.push_back(mk(0,8'h00,0,8'd0,1, 1,0,8'h00,0,9'd1,0));
    vt.push_back(mk(0,8'h00,1,8'd1,0, 0,0,8'h00,0,9'd1,0));
    vt.push_back(mk(0,8'h00,1,8'd1,0, 0,1,8'h44,0,9'd1,0));
    vt.push_back(mk(0,8'h00,1,8'd1,0, 0,0,8'h00,1,9'd0,0));
    vt.push_back(mk(0,8'h00,1,8'd1,0, 1,0,8'h00,0,9'd0,0));

    cyc();
    chk("rst.rdy", 32'(ready_tx), 1);
    chk("rst.vld", 32'(tx_if.tx_valid), 0);
    chk("rst.done", 32'(tx_done), 0);
    chk("rst.cnt", 32'(fifo_count), 0);
    chk("rst.ov", 32'(overflow), 0);
    chk("rst.ur", 32'(underrun), 0);
    cyc();
    reset = 1'b0;

    tx_if.tx_ready = 1'b1;
    for (int i = 0; i < vt.size(); i++) begin
      wren_fifo_tx = vt[i].wr;
      data_tx      = vt[i].d;
      start_tx     = vt[i].st;
      size_fifo_tx = vt[i].sz;
      clr_flags    = vt[i].clr;
      cyc();
      chk($sformatf("v%0d.rdy", i), 32'(ready_tx),
          32'(vt[i].e_rdy));
      chk($sformatf("v%0d.vld", i), 32'(tx_if.tx_valid),
          32'(vt[i].e_vld));
      if (vt[i].e_vld)
        chk($sformatf("v%0d.byte", i), 32'(tx_if.tx_byte),
            32'(vt[i].e_byte));
      chk($sformatf("v%0d.done", i), 32'(tx_done),
          32'(vt[i].e_done));
      chk($sformatf("v%0d.cnt", i), 32'(fifo_count),
          32'(vt[i].e_cnt));
      chk($sformatf("v%0d.ur", i), 32'(underrun),
          32'(vt[i].e_ur));
      chk($sformatf("v%0d.ov", i), 32'(overflow), 0);
    end
    wren_fifo_tx   = 1'b0;
    start_tx       = 1'b0;
    clr_flags      = 1'b0;
    tx_if.tx_ready = 1'b0;

    // Short packet: 5 stored, 8 requested.
    do_reset();
    for (int i = 0; i < 5; i++) wr_byte(8'(8'hA0 + i));
    chk("ur.cnt", 32'(fifo_count), 5);
    start_pkt(8'd8);
    chk("ur.flag", 32'(underrun), 1);
    recv(-1, 0, 8'h00, 100);
    chk_got("ur", 5, 8'hA0);
    chk("ur.cnt0", 32'(fifo_count), 0);
    chk("ur.sticky", 32'(underrun), 1);
    clr_flags = 1'b1;
    cyc();
    clr_flags = 1'b0;
    chk("ur.clr", 32'(underrun), 0);

    // Overflow: 257th byte dropped; set beats clear.
    do_reset();
    for (int i = 0; i < 256; i++) wr_byte(8'(i));
    chk("ov.full", 32'(fifo_count), 256);
    chk("ov.pre", 32'(overflow), 0);
    wr_byte(8'hEE);
    chk("ov.cnt", 32'(fifo_count), 256);
    chk("ov.set", 32'(overflow), 1);
    clr_flags = 1'b1;
    wr_byte(8'hEE);
    chk("ov.setclr", 32'(overflow), 1);
    cyc();
    clr_flags = 1'b0;
    chk("ov.clr", 32'(overflow), 0);
    start_pkt(8'd255);
    recv(-1, 0, 8'h00, 1000);
    chk_got("ov.a", 255, 0);
    chk("ov.left", 32'(fifo_count), 1);
    start_pkt(8'd1);
    recv(-1, 0, 8'h00, 20);
    chk_got("ov.b", 1, 8'hFF);
    chk("ov.cnt0", 32'(fifo_count), 0);

    // Backpressure on the second byte.
    do_reset();
    for (int i = 0; i < 4; i++) wr_byte(8'(8'h51 + i));
    start_pkt(8'd4);
    recv(1, 4, 8'h52, 100);
    chk_got("bp", 4, 8'h51);
    chk("bp.cnt", 32'(fifo_count), 0);

    // Pointer wrap-around.
    do_reset();
    for (int i = 0; i < 200; i++) wr_byte(8'(i + 8'h30));
    start_pkt(8'd200);
    recv(-1, 0, 8'h00, 1000);
    chk_got("wr.a", 200, 8'h30);
    for (int i = 0; i < 100; i++) wr_byte(8'(i));
    chk("wr.cnt", 32'(fifo_count), 100);
    start_pkt(8'd100);
    recv(-1, 0, 8'h00, 1000);
    chk_got("wr.b", 100, 0);

    // Reset in the middle of a 10-byte packet.
    do_reset();
    for (int i = 0; i < 10; i++) wr_byte(8'(i + 1));
    start_pkt(8'd10);
    tx_if.tx_ready = 1'b1;
    begin
      int nv;
      nv = 0;
      for (int t = 0; t < 40 && nv < 3; t++) begin
        if (tx_if.tx_valid) nv++;
        if (nv < 3) cyc();
      end
      chk("mr.insend", 32'(tx_if.tx_valid), 1);
    end
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    chk("mr.vld", 32'(tx_if.tx_valid), 0);
    chk("mr.rdy", 32'(ready_tx), 1);
    chk("mr.cnt", 32'(fifo_count), 0);
    chk("mr.done", 32'(tx_done), 0);
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk($sformatf("mr.nodone%0d", i), 32'(tx_done), 0);
    end
    start_pkt(8'd4);
    chk("mr.idle", 32'(ready_tx), 1);
    chk("mr.novld", 32'(tx_if.tx_valid), 0);
    chk("mr.ur", 32'(underrun), 1);
    cyc();
    chk("mr.stay", 32'(ready_tx), 1);
    tx_if.tx_ready = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nbad);
    $finish;
  end

endmodule
